// File: rtl/ascon_fsm_ctrl_pkg.sv
// Shared types and constants for the Ascon-128 AEAD encryption controller.
//   type_fsm_state : controller state encoding
//   XB_* / XE_*    : datapath begin/end XOR bypass selects
//   ctrl_out_t     : registered control word presented to the datapath
//   ctrl_decode    : Moore decode of (state, round) into a control word
package ascon_fsm_ctrl_pkg;

  localparam int unsigned ROUND_W      = 4;
  localparam int unsigned ROUNDS_A_DEF = 12;
  localparam int unsigned ROUNDS_B_DEF = 6;

  localparam logic [ROUND_W-1:0] ROUND_LAST    = ROUND_W'(11);
  localparam logic [ROUND_W-1:0] ROUND_FIRST_A = ROUND_W'(12 - ROUNDS_A_DEF);
  localparam logic [ROUND_W-1:0] ROUND_FIRST_B = ROUND_W'(12 - ROUNDS_B_DEF);

  localparam logic [1:0] XB_NONE     = 2'd0;
  localparam logic [1:0] XB_DATA     = 2'd1;
  localparam logic [1:0] XB_KEY      = 2'd2;
  localparam logic [1:0] XB_DATA_KEY = 2'd3;

  localparam logic [1:0] XE_NONE   = 2'd0;
  localparam logic [1:0] XE_KEY    = 2'd1;
  localparam logic [1:0] XE_DOMAIN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_PT,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } type_fsm_state;

  typedef struct packed {
    logic               block_ready;
    logic               input_mode;
    logic [ROUND_W-1:0] round;
    logic               en_state;
    logic [1:0]         xb;
    logic [1:0]         xe;
    logic               en_cipher;
    logic               en_tag;
    logic               done;
  } ctrl_out_t;

  // Control word for a given state and round index; first_a/first_b are the
  // opening round indices of p^a and p^b respectively.
  function automatic ctrl_out_t ctrl_decode(input type_fsm_state     st,
                                            input logic [ROUND_W-1:0] rnd,
                                            input logic [ROUND_W-1:0] first_a,
                                            input logic [ROUND_W-1:0] first_b);
    ctrl_out_t o;
    o       = '0;
    o.round = rnd;
    case (st)
      ST_INIT: begin
        o.en_state   = 1'b1;
        o.input_mode = (rnd == first_a);
        if (rnd == ROUND_LAST) o.xe = XE_KEY;
      end
      ST_WAIT_AD, ST_WAIT_PT: o.block_ready = 1'b1;
      ST_AD: begin
        o.en_state = 1'b1;
        if (rnd == first_b)    o.xb = XB_DATA;
        if (rnd == ROUND_LAST) o.xe = XE_DOMAIN;
      end
      ST_PT: begin
        o.en_state = 1'b1;
        if (rnd == first_b) begin
          o.xb        = XB_DATA;
          o.en_cipher = 1'b1;
        end
      end
      ST_FINAL: begin
        o.en_state = 1'b1;
        // Last plaintext block is absorbed together with the key at finalisation start.
        if (rnd == first_a) begin
          o.xb        = XB_DATA_KEY;
          o.en_cipher = 1'b1;
        end
        if (rnd == ROUND_LAST) begin
          o.xe     = XE_KEY;
          o.en_tag = 1'b1;
        end
      end
      ST_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ascon_fsm_ctrl_if.sv
// Host/datapath bundle of the Ascon controller.
//   slave  : controller side (samples start/data_valid, drives datapath controls)
//   master : host/datapath side
// Optional ASCON_ABORT_EN adds abort_i (host requests message abort).
interface ascon_fsm_ctrl_if;
  import ascon_fsm_ctrl_pkg::*;

  logic               start_i;
  logic               data_valid_i;
`ifdef ASCON_ABORT_EN
  logic               abort_i;
`endif
  logic               block_ready_o;
  logic               input_mode_o;
  logic [ROUND_W-1:0] round_o;
  logic               enable_state_o;
  logic [1:0]         bypass_xor_begin_o;
  logic [1:0]         bypass_xor_end_o;
  logic               enable_cipher_o;
  logic               enable_tag_o;
  logic               done_o;

  modport slave (
    input  start_i,
    input  data_valid_i,
`ifdef ASCON_ABORT_EN
    input  abort_i,
`endif
    output block_ready_o,
    output input_mode_o,
    output round_o,
    output enable_state_o,
    output bypass_xor_begin_o,
    output bypass_xor_end_o,
    output enable_cipher_o,
    output enable_tag_o,
    output done_o
  );

  modport master (
    output start_i,
    output data_valid_i,
`ifdef ASCON_ABORT_EN
    output abort_i,
`endif
    input  block_ready_o,
    input  input_mode_o,
    input  round_o,
    input  enable_state_o,
    input  bypass_xor_begin_o,
    input  bypass_xor_end_o,
    input  enable_cipher_o,
    input  enable_tag_o,
    input  done_o
  );
endinterface

// File: rtl/ascon_fsm_ctrl_round_counter.sv
// Round index counter for the Ascon permutation.
//   clk_i, rst_i   : clock, async active-high reset
//   clear_i        : force index to 0 (highest priority)
//   load_i         : load load_val_i (first round of the next permutation)
//   inc_i          : advance one round, saturating at the last round
//   round_nxt_o    : index the register takes at the next edge
//   last_o         : current index is the last round
module ascon_fsm_ctrl_round_counter
  import ascon_fsm_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [ROUND_W-1:0] load_val_i,
  input  logic               inc_i,
  output logic [ROUND_W-1:0] round_nxt_o,
  output logic               last_o
);

  logic [ROUND_W-1:0] round_q;
  logic [ROUND_W-1:0] round_d;

  assign last_o = (round_q == ROUND_LAST);

  // Next index: clear > load > saturating increment > hold.
  always_comb begin
    round_d = round_q;
    if (clear_i) begin
      round_d = '0;
    end else if (load_i) begin
      round_d = load_val_i;
    end else if (inc_i && !last_o) begin
      round_d = round_q + ROUND_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) round_q <= '0;
    else       round_q <= round_d;
  end

  assign round_nxt_o = round_d;

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Moore controller sequencing the Ascon-128 datapath for one AEAD encryption:
// init (p^a), one AD block, NB_BLOCKS plaintext blocks, finalisation (p^a).
//   clock_i, reset_i : clock, async active-high reset
//   bus (slave)      : start_i/data_valid_i in; block_ready_o, input_mode_o,
//                      round_o, enable_state_o, bypass_xor_begin_o/end_o,
//                      enable_cipher_o, enable_tag_o, done_o out
// Macro ASCON_ABORT_EN: bus.abort_i returns any active message to IDLE.
module ascon_fsm_ctrl
  import ascon_fsm_ctrl_pkg::*;
#(
  parameter int unsigned NB_BLOCKS = 4,
  parameter int unsigned ROUNDS_A  = ROUNDS_A_DEF,
  parameter int unsigned ROUNDS_B  = ROUNDS_B_DEF
) (
  input logic             clock_i,
  input logic             reset_i,
  ascon_fsm_ctrl_if.slave bus
);

  // A single-block message still needs a 1-bit counter.
  localparam int unsigned BLK_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
  localparam logic [ROUND_W-1:0] FIRST_A  = ROUND_W'(12 - ROUNDS_A);
  localparam logic [ROUND_W-1:0] FIRST_B  = ROUND_W'(12 - ROUNDS_B);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(NB_BLOCKS - 1);

  type_fsm_state      state_q;
  type_fsm_state      state_d;
  logic [BLK_W-1:0]   blk_q;
  logic [BLK_W-1:0]   blk_d;
  ctrl_out_t          out_q;

  logic               rc_clear;
  logic               rc_load;
  logic [ROUND_W-1:0] rc_load_val;
  logic               rc_inc;
  logic [ROUND_W-1:0] round_d;
  logic               rc_last;

  ascon_fsm_ctrl_round_counter u_round_counter (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .clear_i     (rc_clear),
    .load_i      (rc_load),
    .load_val_i  (rc_load_val),
    .inc_i       (rc_inc),
    .round_nxt_o (round_d),
    .last_o      (rc_last)
  );

  // Next state, counter controls.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rc_clear    = 1'b0;
    rc_load     = 1'b0;
    rc_load_val = FIRST_A;
    rc_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_INIT;
          rc_load = 1'b1;
        end
      end
      ST_INIT: begin
        rc_inc = 1'b1;
        if (rc_last) state_d = ST_WAIT_AD;
      end
      ST_WAIT_AD: begin
        if (bus.data_valid_i) begin
          state_d     = ST_AD;
          rc_load     = 1'b1;
          rc_load_val = FIRST_B;
        end
      end
      ST_AD: begin
        rc_inc = 1'b1;
        if (rc_last) state_d = ST_WAIT_PT;
      end
      ST_WAIT_PT: begin
        if (bus.data_valid_i) begin
          rc_load = 1'b1;
          if (blk_q == BLK_LAST) begin
            state_d = ST_FINAL;
          end else begin
            state_d     = ST_PT;
            rc_load_val = FIRST_B;
          end
        end
      end
      ST_PT: begin
        rc_inc = 1'b1;
        if (rc_last) begin
          state_d = ST_WAIT_PT;
          blk_d   = blk_q + BLK_W'(1);
        end
      end
      ST_FINAL: begin
        rc_inc = 1'b1;
        if (rc_last) begin
          state_d  = ST_DONE;
          rc_clear = 1'b1;
          blk_d    = '0;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rc_clear = 1'b1;
        blk_d    = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        rc_clear = 1'b1;
        blk_d    = '0;
      end
    endcase
`ifdef ASCON_ABORT_EN
    // Abort overrides everything; the registered outputs then decode IDLE.
    if (bus.abort_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      rc_clear = 1'b1;
      rc_load  = 1'b0;
      rc_inc   = 1'b0;
      blk_d    = '0;
    end
`endif
  end

  // State and outputs; outputs decode the upcoming state so they align with it.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      out_q   <= ctrl_decode(state_d, round_d, FIRST_A, FIRST_B);
    end
  end

  assign bus.block_ready_o      = out_q.block_ready;
  assign bus.input_mode_o       = out_q.input_mode;
  assign bus.round_o            = out_q.round;
  assign bus.enable_state_o     = out_q.en_state;
  assign bus.bypass_xor_begin_o = out_q.xb;
  assign bus.bypass_xor_end_o   = out_q.xe;
  assign bus.enable_cipher_o    = out_q.en_cipher;
  assign bus.enable_tag_o       = out_q.en_tag;
  assign bus.done_o             = out_q.done;

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Self-checking bench for ascon_fsm_ctrl (NB_BLOCKS=4 and NB_BLOCKS=1 instances).
// Expected per-cycle control words come from a message-level trace model.
module tb_ascon_fsm_ctrl;
  import ascon_fsm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_fsm_ctrl_if bus4 ();
  ascon_fsm_ctrl_if bus1 ();

  ascon_fsm_ctrl #(.NB_BLOCKS(4), .ROUNDS_A(12), .ROUNDS_B(6)) dut4 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus4)
  );

  ascon_fsm_ctrl #(.NB_BLOCKS(1), .ROUNDS_A(12), .ROUNDS_B(6)) dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus1)
  );

  // One cycle of stimulus and the control word required during that cycle.
  // exp = {block_ready, input_mode, round[3:0], en_state, xb[1:0], xe[1:0], en_cipher, en_tag, done}
  typedef struct packed {
    logic        start;
    logic        dv;
    logic        abort;
    logic [13:0] exp;
  } vec_t;

  localparam int K_INIT  = 0;
  localparam int K_AD    = 1;
  localparam int K_PT    = 2;
  localparam int K_FINAL = 3;

  vec_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_cipher, n_tag, n_done;
  logic noise = 1'b0;

  function automatic logic [13:0] pk(input logic br, input logic im, input logic [3:0] rnd,
                                     input logic es, input logic [1:0] xb, input logic [1:0] xe,
                                     input logic ec, input logic et, input logic dn);
    return {br, im, rnd, es, xb, xe, ec, et, dn};
  endfunction

  function automatic void push(input logic st, input logic dv, input logic [13:0] e);
    vec_t v;
    v.start = st;
    v.dv    = dv;
    v.abort = 1'b0;
    v.exp   = e;
    q.push_back(v);
  endfunction

  function automatic void add_idle(input int n, input logic go);
    for (int i = 0; i < n; i++)
      push(go && (i == n - 1), 1'b1, pk(1'b0, 1'b0, 4'd0, 1'b0, XB_NONE, XE_NONE, 1'b0, 1'b0, 1'b0));
  endfunction

  // One permutation: p^a (INIT/FINAL) runs rounds 0..11, p^b (AD/PT) rounds 6..11.
  function automatic void add_perm(input int kind);
    int         first;
    logic       im, ec, et;
    logic [1:0] xb, xe;
    first = (kind == K_INIT || kind == K_FINAL) ? 0 : 6;
    for (int r = first; r <= 11; r++) begin
      im = 1'b0; ec = 1'b0; et = 1'b0; xb = XB_NONE; xe = XE_NONE;
      case (kind)
        K_INIT: begin
          im = (r == 0);
          if (r == 11) xe = XE_KEY;
        end
        K_AD: begin
          if (r == 6)  xb = XB_DATA;
          if (r == 11) xe = XE_DOMAIN;
        end
        K_PT: if (r == 6) begin xb = XB_DATA; ec = 1'b1; end
        default: begin
          if (r == 0)  begin xb = XB_DATA_KEY; ec = 1'b1; end
          if (r == 11) begin xe = XE_KEY; et = 1'b1; end
        end
      endcase
      push(noise, 1'b1, pk(1'b0, im, 4'(r), 1'b1, xb, xe, ec, et, 1'b0));
    end
  endfunction

  // Block request: 'stall' cycles with data_valid low, then one accepted cycle.
  function automatic void add_wait(input int stall);
    for (int i = 0; i <= stall; i++)
      push(noise, (i == stall), pk(1'b1, 1'b0, 4'd11, 1'b0, XB_NONE, XE_NONE, 1'b0, 1'b0, 1'b0));
  endfunction

  // Whole message; stall_len extra cycles in plaintext wait number stall_blk.
  function automatic void add_msg(input int nb, input int stall_blk, input int stall_len, input logic nz);
    noise = nz;
    add_idle(1, 1'b1);
    add_perm(K_INIT);
    add_wait(0);
    add_perm(K_AD);
    for (int b = 0; b < nb - 1; b++) begin
      add_wait((b == stall_blk) ? stall_len : 0);
      add_perm(K_PT);
    end
    add_wait((stall_blk == nb - 1) ? stall_len : 0);
    add_perm(K_FINAL);
    push(noise, 1'b1, pk(1'b0, 1'b0, 4'd0, 1'b0, XB_NONE, XE_NONE, 1'b0, 1'b0, 1'b1));
    noise = 1'b0;
  endfunction

  function automatic int count_model(input int bitpos);
    int n = 0;
    foreach (q[i]) if (q[i].exp[bitpos]) n++;
    return n;
  endfunction

  function automatic logic [13:0] sample(input int sel);
    if (sel == 1)
      return {bus1.block_ready_o, bus1.input_mode_o, bus1.round_o, bus1.enable_state_o,
              bus1.bypass_xor_begin_o, bus1.bypass_xor_end_o, bus1.enable_cipher_o,
              bus1.enable_tag_o, bus1.done_o};
    return {bus4.block_ready_o, bus4.input_mode_o, bus4.round_o, bus4.enable_state_o,
            bus4.bypass_xor_begin_o, bus4.bypass_xor_end_o, bus4.enable_cipher_o,
            bus4.enable_tag_o, bus4.done_o};
  endfunction

  task automatic drive(input int sel, input logic st, input logic dv);
    if (sel == 1) begin bus1.start_i = st; bus1.data_valid_i = dv; end
    else          begin bus4.start_i = st; bus4.data_valid_i = dv; end
  endtask

  task automatic drive_abort(input int sel, input logic ab);
`ifdef ASCON_ABORT_EN
    if (sel == 1) bus1.abort_i = ab;
    else          bus4.abort_i = ab;
`else
    if (ab && sel < 0) $display("abort request dropped");
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
    end
  endtask

  // Replays the queued trace: drives inputs and compares outputs every cycle.
  task automatic play(input int sel, input string name, input bit drain);
    logic [13:0] got;
    n_cipher = 0; n_tag = 0; n_done = 0;
    foreach (q[i]) begin
      @(negedge clk);
      drive(sel, q[i].start, q[i].dv);
      drive_abort(sel, q[i].abort);
      got = sample(sel);
      checks++;
      if (got !== q[i].exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b required %b (br im rnd4 es xb2 xe2 ec et dn)",
                 name, i, got, q[i].exp);
      end
      if (got[2] === 1'b1) n_cipher++;
      if (got[1] === 1'b1) n_tag++;
      if (got[0] === 1'b1) n_done++;
    end
    if (drain) begin
      @(posedge clk);
      #1;
    end
    drive(sel, 1'b0, 1'b0);
    drive_abort(sel, 1'b0);
    q.delete();
  endtask

  initial begin
    drive(4, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    drive_abort(4, 1'b0);
    drive_abort(1, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_outputs_nb4", 32'(sample(4)), 32'd0);
    chk("reset_outputs_nb1", 32'(sample(1)), 32'd0);
    rst = 1'b0;

    // Full message, data_valid always high: start cycle through done cycle = 55 cycles.
    add_msg(4, -1, 0, 1'b0);
    chk("model_len_nb4", 32'(q.size()), 32'd55);
    chk("model_cipher_nb4", 32'(count_model(2)), 32'd4);
    chk("model_init_r11_xe", 32'(q[12].exp[4:3]), 32'(XE_KEY));
    chk("model_ad_r11_xe", 32'(q[19].exp[4:3]), 32'(XE_DOMAIN));
    play(4, "msg_nb4", 1'b1);
    chk("dut_cipher_pulses_nb4", 32'(n_cipher), 32'd4);
    chk("dut_tag_pulses_nb4", 32'(n_tag), 32'd1);
    chk("dut_done_pulses_nb4", 32'(n_done), 32'd1);

    // Five-cycle stall before the second plaintext block; start_i held high outside IDLE.
    add_msg(4, 1, 5, 1'b1);
    chk("model_len_stall", 32'(q.size()), 32'd60);
    chk("model_stall_round", 32'(q[29].exp[11:8]), 32'd11);
    play(4, "stall_nb4", 1'b1);
    chk("dut_done_pulses_stall", 32'(n_done), 32'd1);

    // Reset pulse in the middle of PT round 8, then a clean restart.
    add_msg(4, -1, 0, 1'b0);
    while (q.size() > 24) void'(q.pop_back());
    chk("model_cut_round", 32'(q[23].exp[11:8]), 32'd8);
    play(4, "pre_reset", 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 32'(sample(4)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    add_msg(4, -1, 0, 1'b0);
    play(4, "after_reset", 1'b1);
    chk("dut_done_after_reset", 32'(n_done), 32'd1);

    // Single-block message: AD goes straight to FINAL.
    add_msg(1, -1, 0, 1'b0);
    chk("model_len_nb1", 32'(q.size()), 32'd34);
    chk("model_final_r0_xb_nb1", 32'(q[21].exp[6:5]), 32'(XB_DATA_KEY));
    play(1, "msg_nb1", 1'b1);
    chk("dut_cipher_pulses_nb1", 32'(n_cipher), 32'd1);
    chk("dut_tag_pulses_nb1", 32'(n_tag), 32'd1);
    chk("dut_done_pulses_nb1", 32'(n_done), 32'd1);

`ifdef ASCON_ABORT_EN
    // Abort in FINAL round 5: IDLE next cycle, no tag or done.
    add_msg(4, -1, 0, 1'b0);
    while (q.size() > 48) void'(q.pop_back());
    q[47].abort = 1'b1;
    chk("model_abort_round", 32'(q[47].exp[11:8]), 32'd5);
    add_idle(3, 1'b0);
    play(4, "abort", 1'b1);
    chk("dut_tag_after_abort", 32'(n_tag), 32'd0);
    chk("dut_done_after_abort", 32'(n_done), 32'd0);
    add_msg(4, -1, 0, 1'b0);
    play(4, "after_abort", 1'b1);
    chk("dut_done_after_abort_restart", 32'(n_done), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
